// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and default
// line/clock rates, used by both the transmitter and the receiver.
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int DEFAULT_FREQUENCY = 100_000_000;
    localparam int DEFAULT_BAUDRATE  = 112_000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per oversample tick, integer-truncated.
    function automatic int calc_divisor(input int freq, input int baud);
        return freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Oversample tick generator: one-clk tick every DIVISOR clk cycles, with a
// synchronous clear so each frame starts on a fresh tick phase.
module uart_tx_baud_tick #(
    parameter int DIVISOR = 55
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] r_count;

    // Divisor counter: wraps to zero on terminal count, held at zero by clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Tick fires in the last cycle of each divisor period.
    assign o_tick = !i_clear && (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop
// bit(s); every bit lasts OVERSAMPLE ticks of the divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int FREQUENCY                      = DEFAULT_FREQUENCY,
    parameter int BAUDRATE                       = DEFAULT_BAUDRATE,
    parameter int NUMBER_OF_DATA_BITS_PER_PACKET = 8,
    parameter int NUMBER_OF_STOP_BITS            = 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      tx_start,
    input  logic [NUMBER_OF_DATA_BITS_PER_PACKET-1:0] tx_data,
    output logic                                      tx,
    output logic                                      tx_busy,
    output logic                                      tx_done
);

    localparam int N       = NUMBER_OF_DATA_BITS_PER_PACKET;
    localparam int DIVISOR = calc_divisor(FREQUENCY, BAUDRATE);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] LAST_DATA = 4'(N - 1);
    localparam logic [3:0] LAST_STOP = 4'(NUMBER_OF_STOP_BITS - 1);

    uart_state_t  r_state;
    logic [N-1:0] r_shift;
    logic [3:0]   r_tick_cnt;
    logic [3:0]   r_bit_idx;
    logic         r_tx;
    logic         r_busy;
    logic         r_done;
`ifdef UART_TX_PARITY_EN
    logic         r_parity;
`endif

    logic w_clear;
    logic w_tick;
    logic w_bit_end;

    // Divider and tick counter sit at zero while idle, so acceptance
    // always starts a bit period from a clean phase.
    assign w_clear = (r_state == ST_IDLE);

    uart_tx_baud_tick #(
        .DIVISOR (DIVISOR)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Oversample tick counter: one full wrap marks the end of a bit time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_clear) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == LAST_TICK) ? 4'd0 : r_tick_cnt + 4'd1;
        end
    end

    assign w_bit_end = w_tick && (r_tick_cnt == LAST_TICK);

    // Frame FSM; tx/busy/done are all registered here so the line never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_shift   <= tx_data;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx      <= r_parity;
                            r_state   <= ST_PARITY;
`else
                            r_tx      <= 1'b1;
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The module SHALL have parameter FREQUENCY, default 100000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUDRATE, default 112000, meaning the line bit rate in bits/s.
REQ-003 The module SHALL have parameter NUMBER_OF_DATA_BITS_PER_PACKET, default 8, meaning the data bits per frame (legal range 5..9).
REQ-004 The module SHALL have parameter NUMBER_OF_STOP_BITS, default 1, meaning the stop bits per frame (legal values 1, 2).
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock; all logic is rising-edge.
REQ-006 Port reset_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port tx_start SHALL be an input, 1 bit wide: request to send tx_data, level-sampled.
REQ-008 Port tx_data SHALL be an input, NUMBER_OF_DATA_BITS_PER_PACKET bits wide: the byte to transmit.
REQ-009 Port tx SHALL be an output, 1 bit wide: the serial line, idle high and registered.
REQ-010 Port tx_busy SHALL be an output, 1 bit wide: high from frame acceptance until the end of the last stop bit.
REQ-011 Port tx_done SHALL be an output, 1 bit wide: a one-clk pulse at frame completion.

Function
REQ-012 Divisor SHALL be DIVISOR = FREQUENCY / (BAUDRATE*16), integer-truncated (55 at defaults); one sample tick is issued every DIVISOR clk cycles.
REQ-013 Each bit SHALL last exactly 16 ticks (16*DIVISOR clk cycles, 880 at defaults).
REQ-014 The FSM SHALL have states idle, start, data, parity (macro only) and stop.
REQ-015 In idle with tx_start=1, the block SHALL latch tx_data into a shift register, clear the tick divider and the 16-tick counter, and enter start; tx goes low on the following clk edge.
REQ-016 start SHALL drive tx=0 for 16 ticks, then move to data.
REQ-017 data SHALL drive the shift-register LSB, shift right after each 16 ticks, and move on after NUMBER_OF_DATA_BITS_PER_PACKET bits (bit index 0..N-1, LSB first).
REQ-018 stop SHALL drive tx=1 for NUMBER_OF_STOP_BITS*16 ticks, then return to idle.
REQ-019 tx_done SHALL be 1 in exactly the first clk cycle of idle after stop, and tx_busy SHALL be 0 in that same cycle.
REQ-020 tx_start=1 in that same cycle SHALL be accepted, giving back-to-back frames with no idle bit time.
REQ-021 tx_start SHALL be ignored while tx_busy=1, and tx_data changes after acceptance SHALL not affect the frame in flight.
REQ-022 tx_busy SHALL rise on the clk edge that accepts tx_start.
REQ-023 tx SHALL be driven from a flop only (glitch-free).
REQ-024 The tick divider and bit counters SHALL wrap to 0 on terminal count, with no drift across frames.

Reset
REQ-025 While reset_n=0, the outputs SHALL be tx=1, tx_busy=0 and tx_done=0, with state=idle and all counters and the shift register at 0.
REQ-026 Reset asserted mid-frame SHALL immediately abort the frame with tx=1; no tx_done is issued.
REQ-027 After deassertion, the block SHALL accept a frame on the first clk edge with tx_start=1.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, the parity state SHALL be inserted between data and stop, driving even parity (XOR of the data bits) for 16 ticks.
REQ-029 Without UART_TX_PARITY_EN, the parity state and its logic SHALL not exist, and data SHALL proceed directly to stop.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state encoding constants (idle, start, data, parity, stop), OVERSAMPLE=16, and the default BAUDRATE/FREQUENCY constants, for reuse with the receiver.
REQ-031 One sub-module, uart_tx_baud_tick, SHALL hold the DIVISOR counter with async active-low reset and synchronous clear, emitting a 1-clk tick.

Verification
REQ-032 Defaults, tx_data=0x55, 1-cycle tx_start: tx SHALL read 0,1,0,1,0,1,0,1,0,1, each level held 880 clk cycles, with tx_busy high for 8800 cycles, then one tx_done pulse.
REQ-033 tx_start pulsed again at cycle 3000 of a frame with tx_data=0xFF: that request SHALL be ignored, leaving the frame unchanged with a single tx_done.
REQ-034 tx_start held high with 0xA3 then 0x3C: the second start bit SHALL begin on the clk edge after tx_done, with no extra idle time.
REQ-035 reset_n pulsed low at cycle 4000 of a 0x00 frame: tx SHALL go to 1 asynchronously, with tx_busy=0 and no tx_done; a new 0x81 frame is then sent correctly.
REQ-036 With UART_TX_PARITY_EN, tx_data=0x07: the parity bit SHALL be 1 and the frame 9680 cycles; with 0x03, the parity bit SHALL be 0.
REQ-037 Loopback into the existing receiver at defaults, sending 0x00, 0xFF, 0x5A: the receiver data SHALL match every byte.
